// File: rtl/ir_freq_classifier_pkg.sv
// rtl/ir_freq_classifier_pkg.sv - shared decision codes, nominal periods and band helper
// Downstream decision counters import these same definitions.
package ir_freq_classifier_pkg;

    localparam int CNT_W    = 20;

    localparam int NOM_STOP = 100000;
    localparam int NOM_R_B  = 50000;
    localparam int NOM_R_G  = 33333;
    localparam int NOM_B_G  = 25000;

    typedef enum logic [2:0] {
        DEC_NONE = 3'd0,
        DEC_R_B  = 3'd1,
        DEC_R_G  = 3'd2,
        DEC_B_G  = 3'd3,
        DEC_STOP = 3'd4
    } decision_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    // Inclusive band test: nom - tol <= p <= nom + tol.
    function automatic logic in_band(input int p, input int nom, input int tol);
        return (p >= nom - tol) && (p <= nom + tol);
    endfunction

endpackage

// File: rtl/ir_freq_classifier_if.sv
// rtl/ir_freq_classifier_if.sv - beacon input and measurement result bundle
interface ir_freq_classifier_if;
    import ir_freq_classifier_pkg::*;

    logic             blinky;
    logic [CNT_W-1:0] clk_count;
    logic             done;
    logic [2:0]       decision;

    modport master (output blinky, input clk_count, done, decision);
    modport slave  (input blinky, output clk_count, done, decision);

endinterface

// File: rtl/ir_edge_sync.sv
// rtl/ir_edge_sync.sv - 2-flop synchroniser, optional glitch filter, registered rising-edge pulse
// Optional filter selected by macro IR_GLITCH_FILTER_EN.
module ir_edge_sync #(
    parameter int FILT_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic rise_o
);

    logic s1_q, s2_q, prev_q, rise_q;
    logic level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din_i;
            s2_q <= s1_q;
        end
    end

`ifdef IR_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_CYC + 1);

    logic          filt_q;
    logic [FW-1:0] stab_q;

    // The filtered level flips only after FILT_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            stab_q <= '0;
        end else if (s2_q == filt_q) begin
            stab_q <= '0;
        end else if (stab_q == FW'(FILT_CYC - 1)) begin
            filt_q <= s2_q;
            stab_q <= '0;
        end else begin
            stab_q <= stab_q + FW'(1);
        end
    end

    assign level = filt_q;
`else
    assign level = s2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= level;
            rise_q <= level & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/ir_freq_classifier.sv
// rtl/ir_freq_classifier.sv - measures IR beacon period and classifies it into a colour code
// Optional glitch filter in ir_edge_sync via macro IR_GLITCH_FILTER_EN.
module ir_freq_classifier
    import ir_freq_classifier_pkg::*;
#(
    parameter int TOL_CYC     = 2000,
    parameter int TIMEOUT_CYC = 250000,
    parameter int FILT_CYC    = 8,
    parameter int STOP_NOM    = NOM_STOP,
    parameter int RB_NOM      = NOM_R_B,
    parameter int RG_NOM      = NOM_R_G,
    parameter int BG_NOM      = NOM_B_G
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ir_freq_classifier_if.slave  bus
);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic             rise;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] clk_count_q, clk_count_d;
    logic             done_q, done_d;
    decision_e        decision_q, decision_d;
    logic [CNT_W-1:0] period;

    // Assert asynchronously, release aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    ir_edge_sync #(.FILT_CYC(FILT_CYC)) u_edge_sync (
        .clk    (clk),
        .rst_n  (rst_int_n),
        .din_i  (bus.blinky),
        .rise_o (rise)
    );

    function automatic decision_e classify(input logic [CNT_W-1:0] p);
        int v;
        v = int'({12'd0, p});
        if (in_band(v, STOP_NOM, TOL_CYC)) return DEC_STOP;
        if (in_band(v, RB_NOM,   TOL_CYC)) return DEC_R_B;
        if (in_band(v, RG_NOM,   TOL_CYC)) return DEC_R_G;
        if (in_band(v, BG_NOM,   TOL_CYC)) return DEC_B_G;
        return DEC_NONE;
    endfunction

    assign period = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clk_count_d = clk_count_q;
        decision_d  = decision_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // An edge coinciding with the timeout wins.
                if (rise) begin
                    clk_count_d = period;
                    decision_d  = classify(period);
                    done_d      = 1'b1;
                    cnt_d       = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    clk_count_d = CNT_W'(TIMEOUT_CYC);
                    decision_d  = DEC_NONE;
                    done_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = period;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            clk_count_q <= '0;
            done_q      <= 1'b0;
            decision_q  <= DEC_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clk_count_q <= clk_count_d;
            done_q      <= done_d;
            decision_q  <= decision_d;
        end
    end

    assign bus.clk_count = clk_count_q;
    assign bus.done      = done_q;
    assign bus.decision  = decision_q;

endmodule
